alu_mul_seq: RTL

- Multi-cycle unsigned multiplier controller that sequences the shared 32-bit ALU in ADD mode, using shift-and-add.
- Drives the ALU's A/B/ALUop inputs and consumes its Result/CarryOut.
- Produces a 2*DATA_WIDTH product over a valid/ready handshake.
- Sits beside the ALU in the execution stage and serves multi-cycle MUL instructions.

---
 rtl/alu_mul_seq_if.sv | 33 +++
 rtl/alu_mul_seq.sv | 107 ++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Handshake and ALU-side bus of the sequential multiplier.
// slave  : the multiplier controller itself.
// master : the requester/consumer together with the shared ALU.
interface alu_mul_seq_if #(
    parameter int DATA_WIDTH = 32
);
    // operand request
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_A;
    logic [DATA_WIDTH-1:0] in_B;
    // product response
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_hi;
    logic [DATA_WIDTH-1:0] out_lo;
    // shared ALU
    logic [DATA_WIDTH-1:0] alu_A;
    logic [DATA_WIDTH-1:0] alu_B;
    logic [2:0]            alu_ALUop;
    logic [DATA_WIDTH-1:0] alu_Result;
    logic                  alu_CarryOut;

    modport slave (
        input  in_valid, in_A, in_B, out_ready, alu_Result, alu_CarryOut,
        output in_ready, out_valid, out_hi, out_lo, alu_A, alu_B, alu_ALUop
    );

    modport master (
        output in_valid, in_A, in_B, out_ready, alu_Result, alu_CarryOut,
        input  in_ready, out_valid, out_hi, out_lo, alu_A, alu_B, alu_ALUop
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-and-add multiplier that borrows the shared ALU
// in ADD mode, one partial-product bit per cycle, W+? cycles per product.
// Optional feature macro: ALU_MUL_ZERO_BYPASS_EN -- when defined, a zero
// operand skips the CALC loop and goes straight to DONE with a zero product.
module alu_mul_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic          clk,
    input  logic          rst,
    alu_mul_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0]           ALU_ADD  = 3'b010;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

    state_t                state_q;
    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplr_q;
    logic [DATA_WIDTH-1:0] hi_q;
    logic [DATA_WIDTH-1:0] lo_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  in_ready_q;
    logic                  out_valid_q;

    // one shift-and-add step: ALU sum (with carry) lands in hi, its LSB
    // shifts down into the top of lo
    logic [DATA_WIDTH-1:0] hi_d;
    logic [DATA_WIDTH-1:0] lo_d;
    assign {hi_d, lo_d} = {bus.alu_CarryOut, bus.alu_Result, lo_q[DATA_WIDTH-1:1]};

    // ALU is always in ADD; B is gated to zero outside CALC so the ALU
    // result is harmless whenever we are not stepping
    assign bus.alu_ALUop = ALU_ADD;
    assign bus.alu_A     = hi_q;
    assign bus.alu_B     = (state_q == CALC && mplr_q[0]) ? mcand_q : '0;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_hi    = hi_q;
    assign bus.out_lo    = lo_q;

    // control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            mplr_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        mcand_q    <= bus.in_A;
                        mplr_q     <= bus.in_B;
                        hi_q       <= '0;
                        lo_q       <= '0;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
`ifdef ALU_MUL_ZERO_BYPASS_EN
                        if (bus.in_A == '0 || bus.in_B == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    hi_q   <= hi_d;
                    lo_q   <= lo_d;
                    mplr_q <= mplr_q >> 1;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    // hold hi/lo until the consumer takes them
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end
endmodule
